// File: rtl/wb_lmmi_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-LMMI bridge family.
package wb_lmmi_pkg;

    // Bridge sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RDWAIT,
        DRAIN,
        ACK,
        ERR
    } state_e;

    // Reasons a transfer can end in wb_err, handy when printing debug traces.
    typedef enum logic [1:0] {
        MISALIGN,
        RANGE,
        PARTIAL,
        TIMEOUT
    } err_cause_e;

    // Number of byte-address bits below one data word.
    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/wb_lmmi_bridge_if.sv
// Bus bundles for the Wishbone-classic side and the LMMI side of the bridge.
interface wb_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [ADDR_W-1:0]     wb_adr;
    logic [DATA_W/8-1:0]   wb_sel;
    logic [DATA_W-1:0]     wb_dat_w;
    logic                  wb_ack;
    logic                  wb_err;
    logic [DATA_W-1:0]     wb_dat_r;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
        input  wb_ack, wb_err, wb_dat_r
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
        output wb_ack, wb_err, wb_dat_r
    );
endinterface

interface lmmi_if #(
    parameter int OFFSET_W = 16,
    parameter int DATA_W   = 32
);
    logic                  lmmi_request;
    logic                  lmmi_wr_rdn;
    logic [OFFSET_W-1:0]   lmmi_offset;
    logic [DATA_W-1:0]     lmmi_wdata;
    logic                  lmmi_ready;
    logic                  lmmi_rdata_valid;
    logic [DATA_W-1:0]     lmmi_rdata;

    modport master (
        output lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata,
        input  lmmi_ready, lmmi_rdata_valid, lmmi_rdata
    );

    modport slave (
        input  lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata,
        output lmmi_ready, lmmi_rdata_valid, lmmi_rdata
    );
endinterface

// File: rtl/wb_lmmi_bridge_timeout_cnt.sv
// Loadable up/down counter with synchronous clear and an expiry flag,
// shared by the LMMI masters to bound how long they wait on the hard IP.
module lmmi_timeout_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over load, load wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign expired = up ? (cnt_q == limit) : (cnt_q == '0);

endmodule

// File: rtl/wb_lmmi_bridge.sv
// Wishbone-classic slave to LMMI master bridge with decode checking,
// bounded waits, abort handling and a saturating error counter.
module wb_lmmi_bridge
    import wb_lmmi_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 18,
    parameter int OFFSET_W    = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_if.slave               wb,
    lmmi_if.master            lmmi,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int                  ADDR_LSB = addr_lsb(DATA_W);
    localparam int                  TOP_BIT  = ADDR_LSB + OFFSET_W;
    localparam int                  TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]       TO_LIMIT = TW'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0]   LSB_MASK = ADDR_W'((1 << ADDR_LSB) - 1);
    localparam logic [DATA_W/8-1:0] SEL_ALL  = '1;

    state_e                state_q, state_d;
    logic                  wb_ack_q, wb_ack_d;
    logic                  wb_err_q, wb_err_d;
    logic [DATA_W-1:0]     wb_dat_r_q, wb_dat_r_d;
    logic                  lmmi_request_q, lmmi_request_d;
    logic                  lmmi_wr_rdn_q, lmmi_wr_rdn_d;
    logic [OFFSET_W-1:0]   lmmi_offset_q, lmmi_offset_d;
    logic [DATA_W-1:0]     lmmi_wdata_q, lmmi_wdata_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

    logic                  new_req;
    logic                  decode_err;
    logic                  to_clr;
    logic                  to_en;
    logic                  to_expired;
    logic [TW-1:0]         to_cnt;

    // The wait budget restarts on every state change and only runs while
    // the bridge is waiting on the LMMI side.
    assign to_clr = (state_d != state_q);
    assign to_en  = (state_q inside {REQ, RDWAIT, DRAIN});

    lmmi_timeout_cnt #(
        .W (TW)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .ld      (1'b0),
        .ld_val  ('0),
        .en      (to_en),
        .up      (1'b1),
        .limit   (TO_LIMIT),
        .cnt     (to_cnt),
        .expired (to_expired)
    );

    // Request qualification and address/select sanity checks. Reads ignore
    // wb_sel because LMMI always returns a full word.
    always_comb begin
        new_req    = wb.wb_cyc & wb.wb_stb & ~wb_ack_q & ~wb_err_q;
        decode_err = ((wb.wb_adr & LSB_MASK) != '0)
                   | ((wb.wb_adr >> TOP_BIT) != '0)
                   | (wb.wb_we & (wb.wb_sel != SEL_ALL));
    end

    // Next-state logic. Acceptance beats timeout in the same cycle; a master
    // that leaves after an accepted read forces a drain of the late data.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (new_req) begin
                    state_d = decode_err ? ERR : REQ;
                end
            end
            REQ: begin
                if (lmmi.lmmi_ready) begin
                    if (lmmi_wr_rdn_q) begin
                        state_d = wb.wb_cyc ? ACK : IDLE;
                    end else begin
                        state_d = wb.wb_cyc ? RDWAIT : DRAIN;
                    end
                end else if (!wb.wb_cyc) begin
                    state_d = IDLE;
                end else if (to_expired) begin
                    state_d = ERR;
                end
            end
            RDWAIT: begin
                if (!wb.wb_cyc) begin
                    state_d = lmmi.lmmi_rdata_valid ? IDLE : DRAIN;
                end else if (lmmi.lmmi_rdata_valid) begin
                    state_d = ACK;
                end else if (to_expired) begin
                    state_d = ERR;
                end
            end
            DRAIN: begin
                if (lmmi.lmmi_rdata_valid || to_expired) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the state being entered
    // so every bus-facing signal comes straight from a flop.
    always_comb begin
        wb_ack_d       = (state_d == ACK);
        wb_err_d       = (state_d == ERR);
        lmmi_request_d = (state_d == REQ);
        wb_dat_r_d     = wb_dat_r_q;
        lmmi_wr_rdn_d  = lmmi_wr_rdn_q;
        lmmi_offset_d  = lmmi_offset_q;
        lmmi_wdata_d   = lmmi_wdata_q;
        err_cnt_d      = err_cnt_q;
        if (state_q == IDLE && state_d == REQ) begin
            lmmi_wr_rdn_d = wb.wb_we;
            lmmi_offset_d = wb.wb_adr[ADDR_LSB +: OFFSET_W];
            lmmi_wdata_d  = wb.wb_dat_w;
        end
        if (state_q == RDWAIT && state_d == ACK) begin
            wb_dat_r_d = lmmi.lmmi_rdata;
        end
        if (state_d == ERR && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wb_ack_q       <= 1'b0;
            wb_err_q       <= 1'b0;
            wb_dat_r_q     <= '0;
            lmmi_request_q <= 1'b0;
            lmmi_wr_rdn_q  <= 1'b0;
            lmmi_offset_q  <= '0;
            lmmi_wdata_q   <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            wb_ack_q       <= wb_ack_d;
            wb_err_q       <= wb_err_d;
            wb_dat_r_q     <= wb_dat_r_d;
            lmmi_request_q <= lmmi_request_d;
            lmmi_wr_rdn_q  <= lmmi_wr_rdn_d;
            lmmi_offset_q  <= lmmi_offset_d;
            lmmi_wdata_q   <= lmmi_wdata_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign wb.wb_ack         = wb_ack_q;
    assign wb.wb_err         = wb_err_q;
    assign wb.wb_dat_r       = wb_dat_r_q;
    assign lmmi.lmmi_request = lmmi_request_q;
    assign lmmi.lmmi_wr_rdn  = lmmi_wr_rdn_q;
    assign lmmi.lmmi_offset  = lmmi_offset_q;
    assign lmmi.lmmi_wdata   = lmmi_wdata_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_wb_lmmi_bridge.sv
// Directed bench for wb_lmmi_bridge: a vector table for single transfers
// plus hand-written sequences for waits, aborts, saturation and reset.
module tb_wb_lmmi_bridge;
    import wb_lmmi_pkg::*;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 20;
    localparam int OFFSET_W    = 16;
    localparam int TIMEOUT_CYC = 4;
    localparam int CNT_W       = 3;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [3:0]        sel;
        logic [31:0]       wdata;
        logic [31:0]       rdata;
        logic              is_err;
        err_cause_e        cause;
        logic [15:0]       exp_offset;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    int               n_cmp = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] model_cnt = '0;
    logic [31:0]      last_rd = '0;
    vec_t             vecs[8];

    wb_if   #(.ADDR_W(ADDR_W), .DATA_W(DATA_W))     wb_bus ();
    lmmi_if #(.OFFSET_W(OFFSET_W), .DATA_W(DATA_W)) lmmi_bus ();

    wb_lmmi_bridge #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .OFFSET_W    (OFFSET_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb      (wb_bus),
        .lmmi    (lmmi_bus),
        .err_cnt (err_cnt)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_model();
        if (model_cnt != '1) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic bus_idle();
        wb_bus.wb_cyc = 1'b0;
        wb_bus.wb_stb = 1'b0;
        wb_bus.wb_we  = 1'b0;
    endtask

    task automatic apply_stimulus(input logic we, input logic [ADDR_W-1:0] adr,
                                  input logic [3:0] sel, input logic [31:0] dat);
        wb_bus.wb_cyc   = 1'b1;
        wb_bus.wb_stb   = 1'b1;
        wb_bus.wb_we    = we;
        wb_bus.wb_adr   = adr;
        wb_bus.wb_sel   = sel;
        wb_bus.wb_dat_w = dat;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " ack"},     32'(wb_bus.wb_ack), 32'h0);
        check_output({tag, " err"},     32'(wb_bus.wb_err), 32'h0);
        check_output({tag, " dat_r"},   wb_bus.wb_dat_r, 32'h0);
        check_output({tag, " request"}, 32'(lmmi_bus.lmmi_request), 32'h0);
        check_output({tag, " wr_rdn"},  32'(lmmi_bus.lmmi_wr_rdn), 32'h0);
        check_output({tag, " offset"},  32'(lmmi_bus.lmmi_offset), 32'h0);
        check_output({tag, " wdata"},   lmmi_bus.lmmi_wdata, 32'h0);
        check_output({tag, " err_cnt"}, 32'(err_cnt), 32'h0);
    endtask

    // Main sequence.
    initial begin
        vecs[0] = '{1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, MISALIGN, 16'h0004};
        vecs[1] = '{1'b0, 20'h00020, 4'h0, 32'h0,        32'h12345678, 1'b0, MISALIGN, 16'h0008};
        vecs[2] = '{1'b1, 20'h00003, 4'hF, 32'h11111111, 32'h0,        1'b1, MISALIGN, 16'h0000};
        vecs[3] = '{1'b1, 20'h00010, 4'h3, 32'h22222222, 32'h0,        1'b1, PARTIAL,  16'h0000};
        vecs[4] = '{1'b0, 20'h40000, 4'hF, 32'h0,        32'h0,        1'b1, RANGE,    16'h0000};
        vecs[5] = '{1'b1, 20'h3FFFC, 4'hF, 32'hA5A55A5A, 32'h0,        1'b0, MISALIGN, 16'hFFFF};
        vecs[6] = '{1'b0, 20'h00002, 4'hF, 32'h0,        32'h0,        1'b1, MISALIGN, 16'h0000};
        vecs[7] = '{1'b0, 20'h00004, 4'h1, 32'h0,        32'hCAFEF00D, 1'b0, MISALIGN, 16'h0001};

        bus_idle();
        wb_bus.wb_adr            = '0;
        wb_bus.wb_sel            = '0;
        wb_bus.wb_dat_w          = '0;
        lmmi_bus.lmmi_ready      = 1'b0;
        lmmi_bus.lmmi_rdata_valid = 1'b0;
        lmmi_bus.lmmi_rdata      = '0;

        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Table of single transfers.
        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d adr=0x%05h we=%0d %s", i, vecs[i].adr, vecs[i].we,
                     vecs[i].is_err ? vecs[i].cause.name() : "ok");
            apply_stimulus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdata);
            lmmi_bus.lmmi_ready = 1'b1;
            step();
            if (vecs[i].is_err) begin
                bump_model();
                check_output($sformatf("v%0d err", i), 32'(wb_bus.wb_err), 32'h1);
                check_output($sformatf("v%0d ack", i), 32'(wb_bus.wb_ack), 32'h0);
                check_output($sformatf("v%0d request", i), 32'(lmmi_bus.lmmi_request), 32'h0);
                bus_idle();
                step();
                check_output($sformatf("v%0d err clear", i), 32'(wb_bus.wb_err), 32'h0);
            end else begin
                check_output($sformatf("v%0d request", i), 32'(lmmi_bus.lmmi_request), 32'h1);
                check_output($sformatf("v%0d offset", i), 32'(lmmi_bus.lmmi_offset), 32'(vecs[i].exp_offset));
                check_output($sformatf("v%0d wr_rdn", i), 32'(lmmi_bus.lmmi_wr_rdn), 32'(vecs[i].we));
                if (vecs[i].we) check_output($sformatf("v%0d wdata", i), lmmi_bus.lmmi_wdata, vecs[i].wdata);
                step();
                check_output($sformatf("v%0d request drop", i), 32'(lmmi_bus.lmmi_request), 32'h0);
                if (vecs[i].we) begin
                    check_output($sformatf("v%0d ack", i), 32'(wb_bus.wb_ack), 32'h1);
                end else begin
                    check_output($sformatf("v%0d early ack", i), 32'(wb_bus.wb_ack), 32'h0);
                    lmmi_bus.lmmi_rdata_valid = 1'b1;
                    lmmi_bus.lmmi_rdata       = vecs[i].rdata;
                    step();
                    lmmi_bus.lmmi_rdata_valid = 1'b0;
                    last_rd = vecs[i].rdata;
                    check_output($sformatf("v%0d ack", i), 32'(wb_bus.wb_ack), 32'h1);
                end
                bus_idle();
                step();
                check_output($sformatf("v%0d ack clear", i), 32'(wb_bus.wb_ack), 32'h0);
            end
            check_output($sformatf("v%0d dat_r", i), wb_bus.wb_dat_r, last_rd);
            check_output($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(model_cnt));
        end

        // Read with valid arriving three cycles after acceptance.
        apply_stimulus(1'b0, 20'h00020, 4'hF, 32'h0);
        lmmi_bus.lmmi_ready = 1'b1;
        step();
        check_output("slowrd request", 32'(lmmi_bus.lmmi_request), 32'h1);
        check_output("slowrd offset", 32'(lmmi_bus.lmmi_offset), 32'h0008);
        check_output("slowrd wr_rdn", 32'(lmmi_bus.lmmi_wr_rdn), 32'h0);
        for (int k = 2; k <= 4; k++) begin
            step();
            check_output($sformatf("slowrd wait%0d ack", k), 32'(wb_bus.wb_ack), 32'h0);
        end
        lmmi_bus.lmmi_rdata_valid = 1'b1;
        lmmi_bus.lmmi_rdata       = 32'h12345678;
        step();
        lmmi_bus.lmmi_rdata_valid = 1'b0;
        lmmi_bus.lmmi_rdata       = 32'h0;
        last_rd = 32'h12345678;
        check_output("slowrd ack", 32'(wb_bus.wb_ack), 32'h1);
        check_output("slowrd dat_r", wb_bus.wb_dat_r, last_rd);
        bus_idle();
        step();
        check_output("slowrd ack clear", 32'(wb_bus.wb_ack), 32'h0);
        check_output("slowrd dat_r hold", wb_bus.wb_dat_r, last_rd);

        // Ready never comes: request lasts TIMEOUT_CYC cycles, then an error.
        apply_stimulus(1'b1, 20'h00040, 4'hF, 32'h55AA55AA);
        lmmi_bus.lmmi_ready = 1'b0;
        step();
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            check_output($sformatf("timeout c%0d request", k), 32'(lmmi_bus.lmmi_request), 32'h1);
            check_output($sformatf("timeout c%0d err", k), 32'(wb_bus.wb_err), 32'h0);
            step();
        end
        bump_model();
        check_output("timeout err", 32'(wb_bus.wb_err), 32'h1);
        check_output("timeout request drop", 32'(lmmi_bus.lmmi_request), 32'h0);
        check_output("timeout err_cnt", 32'(err_cnt), 32'(model_cnt));
        bus_idle();
        step();

        // Abort after an accepted read; the late data must vanish silently.
        apply_stimulus(1'b0, 20'h00030, 4'hF, 32'h0);
        lmmi_bus.lmmi_ready = 1'b1;
        step();
        step();
        bus_idle();
        for (int k = 3; k <= 8; k++) begin
            lmmi_bus.lmmi_rdata_valid = (k == 7);
            lmmi_bus.lmmi_rdata       = (k == 7) ? 32'hBAD0BAD0 : 32'h0;
            step();
            check_output($sformatf("abort c%0d ack", k), 32'(wb_bus.wb_ack), 32'h0);
            check_output($sformatf("abort c%0d err", k), 32'(wb_bus.wb_err), 32'h0);
        end
        lmmi_bus.lmmi_rdata_valid = 1'b0;
        check_output("abort dat_r", wb_bus.wb_dat_r, last_rd);
        check_output("abort err_cnt", 32'(err_cnt), 32'(model_cnt));
        apply_stimulus(1'b1, 20'h00044, 4'hF, 32'h0BADF00D);
        step();
        check_output("post-abort request", 32'(lmmi_bus.lmmi_request), 32'h1);
        check_output("post-abort offset", 32'(lmmi_bus.lmmi_offset), 32'h0011);
        check_output("post-abort wdata", lmmi_bus.lmmi_wdata, 32'h0BADF00D);
        step();
        check_output("post-abort ack", 32'(wb_bus.wb_ack), 32'h1);
        bus_idle();
        step();

        // Drive the error counter into saturation.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 20'h00001, 4'hF, 32'h0);
            step();
            bump_model();
            check_output($sformatf("sat%0d err", k), 32'(wb_bus.wb_err), 32'h1);
            check_output($sformatf("sat%0d err_cnt", k), 32'(err_cnt), 32'(model_cnt));
            bus_idle();
            step();
        end

        // Asynchronous reset in the middle of a read wait.
        apply_stimulus(1'b0, 20'h00020, 4'hF, 32'h0);
        lmmi_bus.lmmi_ready = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_cnt = '0;
        last_rd   = '0;
        bus_idle();
        #3;
        rst_n = 1'b1;
        step();
        lmmi_bus.lmmi_rdata_valid = 1'b1;
        lmmi_bus.lmmi_rdata       = 32'h77777777;
        step();
        lmmi_bus.lmmi_rdata_valid = 1'b0;
        check_output("stray ack", 32'(wb_bus.wb_ack), 32'h0);
        check_output("stray dat_r", wb_bus.wb_dat_r, last_rd);
        step();
        check_output("stray err", 32'(wb_bus.wb_err), 32'h0);
        check_output("stray err_cnt", 32'(err_cnt), 32'(model_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
